// File: rtl/pll_rst_pkg.sv
// pll_rst_pkg: shared types and defaults for the PLL-lock reset generator.
// The loss counter in pll_rst_gen is controlled by PLL_RST_GEN_LOSS_CNT_EN.
package pll_rst_pkg;

  // Reset-generator sequencing states.
  typedef enum logic [1:0] {
    WAIT_LOCK,
    STABLE_CNT,
    RUN,
    HOLD
  } pll_state_e;

  localparam int PLL_STABLE_CYCLES_DEF = 1024;
  localparam int PLL_HOLD_CYCLES_DEF   = 16;

  // Width of the shared stable/hold counter: enough to reach max(a,b)-1.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: generic single-bit two-flop synchronizer with a synchronous
// active-high reset that clears both stages to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops give the first stage a full cycle to resolve.
  always_ff @(posedge clk) begin
    // NOTE: flops use non-blocking assignments so both stages sample the
    // pre-edge values; blocking here would collapse the chain to one flop.
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_rst_gen.sv
// pll_rst_gen: turns the asynchronous PLL lock flag into a synchronous reset
// and ready flag for the downstream pipeline. Reset is released only after
// the synchronized lock has stayed high for STABLE_CYCLES cycles; a lock drop
// while running re-asserts reset for at least HOLD_CYCLES cycles.
// Optional feature macro: PLL_RST_GEN_LOSS_CNT_EN builds the saturating
// lock-loss counter; without it lock_loss_cnt is tied to 0.
module pll_rst_gen
  import pll_rst_pkg::*;
#(
  parameter int STABLE_CYCLES = PLL_STABLE_CYCLES_DEF,
  parameter int HOLD_CYCLES   = PLL_HOLD_CYCLES_DEF,
  parameter int LOSS_CNT_W    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pll_lock,
  output logic                  rst_out,
  output logic                  ready,
  output logic                  lock_lost,
  output logic [LOSS_CNT_W-1:0] lock_loss_cnt
);

  localparam int CW = cnt_width(STABLE_CYCLES, HOLD_CYCLES);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);

  logic       lock_s;
  pll_state_e state;
  logic [CW-1:0] cnt;

  // Bring the asynchronous lock flag into the clk domain.
  sync_2ff u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_lock),
    .q   (lock_s)
  );

  // Sequencing FSM; rst_out is registered as (next state != RUN).
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= WAIT_LOCK;
      cnt       <= '0;
      rst_out   <= 1'b1;
      lock_lost <= 1'b0;
    end else begin
      rst_out   <= 1'b1;
      lock_lost <= 1'b0;
      case (state)
        WAIT_LOCK: begin
          if (lock_s) begin
            state <= STABLE_CNT;
            cnt   <= '0;
          end
        end
        STABLE_CNT: begin
          if (!lock_s) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == STABLE_LAST) begin
            state   <= RUN;
            rst_out <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RUN: begin
          if (!lock_s) begin
            state     <= HOLD;
            cnt       <= '0;
            lock_lost <= 1'b1;
          end else begin
            rst_out <= 1'b0;
          end
        end
        HOLD: begin
          // Lock is deliberately ignored so the minimum hold time is honoured.
          if (cnt == HOLD_LAST) begin
            state <= WAIT_LOCK;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= WAIT_LOCK;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign ready = ~rst_out;

`ifdef PLL_RST_GEN_LOSS_CNT_EN
  logic [LOSS_CNT_W-1:0] loss_cnt_q;

  // Count RUN->HOLD transitions, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      loss_cnt_q <= '0;
    end else if ((state == RUN) && !lock_s && (loss_cnt_q != '1)) begin
      loss_cnt_q <= loss_cnt_q + LOSS_CNT_W'(1);
    end
  end

  assign lock_loss_cnt = loss_cnt_q;
`else
  assign lock_loss_cnt = '0;
`endif

endmodule
